// File: rtl/io_port_pkg.sv
// Shared register map and bit positions for the I/O port responder.
package io_port_pkg;

    localparam logic [3:0] ADDR_OUT0    = 4'h0;
    localparam logic [3:0] ADDR_OUT7    = 4'h7;
    localparam logic [3:0] ADDR_IN0     = 4'h8;
    localparam logic [3:0] ADDR_IN1     = 4'h9;
    localparam logic [3:0] ADDR_EDGE    = 4'hA;
    localparam logic [3:0] ADDR_EMASK   = 4'hB;
    localparam logic [3:0] ADDR_TCNT    = 4'hC;
    localparam logic [3:0] ADDR_TRELOAD = 4'hD;
    localparam logic [3:0] ADDR_CTRL    = 4'hE;
    localparam logic [3:0] ADDR_STATUS  = 4'hF;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_AR  = 1;
    localparam int CTRL_TIE = 2;

    localparam int ST_TF = 0;
    localparam int ST_EP = 1;

endpackage

// File: rtl/io_timer.sv
// Prescaled 8-bit down-timer: prescaler, TCNT and the sticky TF flag.
module io_timer #(
    parameter int PRESCALE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       ar_i,
    input  logic [7:0] treload_i,
    input  logic       tcnt_we_i,
    input  logic [7:0] tcnt_wdata_i,
    input  logic       tf_w1c_i,
    output logic [7:0] tcnt_o,
    output logic       tf_o,
    output logic       en_clr_o
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    tcnt_q, tcnt_d;
    logic          tf_q, tf_d;
    logic          tick, expire;

    assign tick   = en_i && (presc_q == PS_LAST);
    assign expire = tick && (tcnt_q == 8'h00);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        presc_d = (en_i && !tick) ? presc_q + PW'(1) : '0;

        tcnt_d = tcnt_q;
        if (tcnt_we_i)
            tcnt_d = tcnt_wdata_i;
        else if (tick && tcnt_q != 8'h00)
            tcnt_d = tcnt_q - 8'h01;
        else if (expire && ar_i)
            tcnt_d = treload_i;

        // A set in the same cycle as the CPU clear must win.
        tf_d = tf_q;
        if (expire)
            tf_d = 1'b1;
        else if (tf_w1c_i)
            tf_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tcnt_q  <= 8'h00;
            tf_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            tf_q    <= tf_d;
        end
    end

    assign tcnt_o   = tcnt_q;
    assign tf_o     = tf_q;
    assign en_clr_o = expire && !ar_i;

endmodule

// File: rtl/io_port_responder.sv
// I/O port bus responder: output latches, synchronized inputs, edge capture, timer, irq.
// Define IO_EDGE_BOTH_EN to make EDGE capture both transitions of IN0.
module io_port_responder
    import io_port_pkg::*;
#(
    parameter int         PRESCALE    = 16,
    parameter logic [7:0] OUT_RESET   = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  io_addr,
    input  logic        io_oe,
    input  logic        io_we,
    inout  wire  [7:0]  io_data,
    input  logic [7:0]  port_in0,
    input  logic [7:0]  port_in1,
    output logic [63:0] port_out,
    output logic        irq
);
    logic [7:0][7:0]             out_q, out_d;
    logic [SYNC_STAGES-1:0][7:0] in0_sync_q, in1_sync_q;
    logic [7:0]                  in0_prev_q;
    logic [7:0]                  edge_q, edge_d, emask_q, emask_d, treload_q, treload_d;
    logic [2:0]                  ctrl_q, ctrl_d;
    logic                        irq_q, irq_d;

    logic [7:0] in0, in1, wdata, rdata, edge_set, tcnt;
    logic       wr, ep, tf, en_clr;

    assign wr    = io_oe && io_we;
    assign wdata = io_data;
    assign in0   = in0_sync_q[SYNC_STAGES-1];
    assign in1   = in1_sync_q[SYNC_STAGES-1];
    assign ep    = |(edge_q & emask_q);

`ifdef IO_EDGE_BOTH_EN
    assign edge_set = in0 ^ in0_prev_q;
`else
    assign edge_set = in0 & ~in0_prev_q;
`endif

    io_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .en_i        (ctrl_q[CTRL_EN]),
        .ar_i        (ctrl_q[CTRL_AR]),
        .treload_i   (treload_q),
        .tcnt_we_i   (wr && io_addr == ADDR_TCNT),
        .tcnt_wdata_i(wdata),
        .tf_w1c_i    (wr && io_addr == ADDR_STATUS && wdata[ST_TF]),
        .tcnt_o      (tcnt),
        .tf_o        (tf),
        .en_clr_o    (en_clr)
    );

    always_comb begin
        out_d     = out_q;
        edge_d    = edge_q;
        emask_d   = emask_q;
        treload_d = treload_q;
        ctrl_d    = ctrl_q;
        if (en_clr)
            ctrl_d[CTRL_EN] = 1'b0;
        if (wr) begin
            case (io_addr) inside
                [ADDR_OUT0:ADDR_OUT7]: out_d[io_addr[2:0]] = wdata;
                ADDR_EDGE:             edge_d = edge_q & ~wdata;
                ADDR_EMASK:            emask_d = wdata;
                ADDR_TRELOAD:          treload_d = wdata;
                ADDR_CTRL:             ctrl_d = wdata[2:0];
                default:               ;
            endcase
        end
        edge_d = edge_d | edge_set;
        irq_d  = (tf && ctrl_q[CTRL_TIE]) || ep;
    end

    always_comb begin
        rdata = 8'h00;
        case (io_addr) inside
            [ADDR_OUT0:ADDR_OUT7]: rdata = out_q[io_addr[2:0]];
            ADDR_IN0:              rdata = in0;
            ADDR_IN1:              rdata = in1;
            ADDR_EDGE:             rdata = edge_q;
            ADDR_EMASK:            rdata = emask_q;
            ADDR_TCNT:             rdata = tcnt;
            ADDR_TRELOAD:          rdata = treload_q;
            ADDR_CTRL:             rdata = {5'b0, ctrl_q};
            default: begin
                rdata[ST_TF] = tf;
                rdata[ST_EP] = ep;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= {8{OUT_RESET}};
            in0_sync_q <= '0;
            in1_sync_q <= '0;
            in0_prev_q <= 8'h00;
            edge_q     <= 8'h00;
            emask_q    <= 8'h00;
            treload_q  <= 8'h00;
            ctrl_q     <= 3'b000;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            in0_sync_q <= {in0_sync_q[SYNC_STAGES-2:0], port_in0};
            in1_sync_q <= {in1_sync_q[SYNC_STAGES-2:0], port_in1};
            in0_prev_q <= in0;
            edge_q     <= edge_d;
            emask_q    <= emask_d;
            treload_q  <= treload_d;
            ctrl_q     <= ctrl_d;
            irq_q      <= irq_d;
        end
    end

    assign io_data  = (io_oe && !io_we) ? rdata : 8'hzz;
    assign port_out = out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Scoreboard bench for io_port_responder: stimulus queues expectations, a negedge monitor checks them.
module tb_io_port_responder;
    import io_port_pkg::*;

    localparam int         PRESCALE    = 16;
    localparam logic [7:0] OUT_RESET   = 8'h00;
    localparam int         SYNC_STAGES = 2;

    typedef enum logic [1:0] {K_DATA, K_Z, K_IRQ, K_POUT} kind_t;
    typedef struct {
        kind_t       kind;
        string       name;
        logic [63:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  io_addr;
    logic        io_oe, io_we;
    logic [7:0]  tb_drv;
    logic        tb_en;
    wire  [7:0]  io_data;
    logic [7:0]  port_in0, port_in1;
    logic [63:0] port_out;
    logic        irq;

    exp_t sb_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    assign io_data = tb_en ? tb_drv : 8'hzz;

    always #5 clk = ~clk;

    io_port_responder #(
        .PRESCALE   (PRESCALE),
        .OUT_RESET  (OUT_RESET),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .io_addr (io_addr),
        .io_oe   (io_oe),
        .io_we   (io_we),
        .io_data (io_data),
        .port_in0(port_in0),
        .port_in1(port_in1),
        .port_out(port_out),
        .irq     (irq)
    );

    // Monitor: consumes every pending expectation half a cycle after the driving edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            n_cmp++;
            case (cur.kind)
                K_DATA: if (io_data !== cur.exp[7:0]) begin
                    n_bad++;
                    $display("FAIL %s: io_data=%h expected=%h", cur.name, io_data, cur.exp[7:0]);
                end
                K_Z: if (io_data !== 8'hzz) begin
                    n_bad++;
                    $display("FAIL %s: io_data=%h expected=zz", cur.name, io_data);
                end
                K_IRQ: if (irq !== cur.exp[0]) begin
                    n_bad++;
                    $display("FAIL %s: irq=%b expected=%b", cur.name, irq, cur.exp[0]);
                end
                default: if (port_out !== cur.exp) begin
                    n_bad++;
                    $display("FAIL %s: port_out=%h expected=%h", cur.name, port_out, cur.exp);
                end
            endcase
        end
    end

    task automatic push(input kind_t k, input string name, input logic [63:0] exp);
        exp_t e;
        e.kind = k;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        io_addr = a; io_oe = 1'b1; io_we = 1'b1; tb_drv = d; tb_en = 1'b1;
        cycles(1);
        io_oe = 1'b0; io_we = 1'b0; tb_en = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [7:0] exp, input string name);
        io_addr = a; io_oe = 1'b1; io_we = 1'b0; tb_en = 1'b0;
        push(K_DATA, name, {56'h0, exp});
        cycles(1);
        io_oe = 1'b0;
    endtask

    task automatic chk_z(input string name);
        push(K_Z, name, 64'h0);
        cycles(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] fall_exp;
        reset = 1'b1; io_addr = 4'h0; io_oe = 1'b0; io_we = 1'b0;
        tb_drv = 8'h00; tb_en = 1'b0; port_in0 = 8'h00; port_in1 = 8'h00;
        cycles(3);
        reset = 1'b0;

        // Reset state
        push(K_IRQ, "rst_irq", 64'h0);
        push(K_POUT, "rst_port_out", {8{OUT_RESET}});
        chk_z("rst_bus_z");
        bus_read(ADDR_OUT0, OUT_RESET, "rst_out0");
        bus_read(ADDR_CTRL, 8'h00, "rst_ctrl");

        // Output register write/readback and read-only/unused bits
        bus_write(4'h3, 8'hA5);
        bus_read(4'h3, 8'hA5, "out3_read");
        push(K_POUT, "out3_port_out", {OUT_RESET, OUT_RESET, OUT_RESET, OUT_RESET,
                                        8'hA5, OUT_RESET, OUT_RESET, OUT_RESET});
        chk_z("idle_bus_z");
        bus_write(ADDR_IN0, 8'hFF);
        bus_read(ADDR_IN0, 8'h00, "in0_ro_write");
        bus_write(ADDR_CTRL, 8'hF8);
        bus_read(ADDR_CTRL, 8'h00, "ctrl_high_bits_zero");

        // Edge capture on IN0[2], level on IN1
        port_in0 = 8'h04;
        port_in1 = 8'h5A;
        cycles(2);
        bus_read(ADDR_EDGE, 8'h00, "edge_before_sync");
        bus_read(ADDR_EDGE, 8'h04, "edge_set");
        bus_read(ADDR_IN0, 8'h04, "in0_sync");
        bus_read(ADDR_IN1, 8'h5A, "in1_sync");
        bus_write(ADDR_EMASK, 8'h04);
        push(K_IRQ, "irq_not_yet", 64'h0);
        cycles(1);
        push(K_IRQ, "irq_on_ep", 64'h1);
        bus_read(ADDR_STATUS, 8'h02, "status_ep");
        bus_write(ADDR_EDGE, 8'h04);
        push(K_IRQ, "irq_lag_after_w1c", 64'h1);
        bus_read(ADDR_EDGE, 8'h00, "edge_w1c");
        push(K_IRQ, "irq_cleared", 64'h0);
        port_in0 = 8'h00;
        cycles(4);
`ifdef IO_EDGE_BOTH_EN
        fall_exp = 8'h04;
`else
        fall_exp = 8'h00;
`endif
        bus_read(ADDR_EDGE, fall_exp, "edge_falling");
        bus_write(ADDR_EDGE, 8'hFF);

        // Auto-reload timer: TRELOAD=3, TCNT=3, EN|AR|TIE
        bus_write(ADDR_TRELOAD, 8'h03);
        bus_write(ADDR_TCNT, 8'h03);
        bus_write(ADDR_CTRL, 8'h07);
        cycles(63);
        bus_read(ADDR_STATUS, 8'h00, "tf_before_64");
        bus_read(ADDR_STATUS, 8'h01, "tf_at_64");
        push(K_IRQ, "irq_tf_tie", 64'h1);
        bus_read(ADDR_TCNT, 8'h03, "tcnt_reloaded");
        bus_write(ADDR_STATUS, 8'h01);
        cycles(60);
        bus_read(ADDR_STATUS, 8'h00, "tf_before_128");
        bus_read(ADDR_STATUS, 8'h01, "tf_at_128");
        bus_write(ADDR_STATUS, 8'h01);
        cycles(61);
        bus_write(ADDR_STATUS, 8'h01);
        bus_read(ADDR_STATUS, 8'h01, "tf_set_beats_w1c");

        // One-shot timer: AR=0, TCNT=1
        bus_write(ADDR_CTRL, 8'h00);
        bus_write(ADDR_STATUS, 8'h01);
        bus_write(ADDR_TCNT, 8'h01);
        bus_write(ADDR_CTRL, 8'h05);
        cycles(31);
        bus_read(ADDR_CTRL, 8'h05, "ctrl_before_expire");
        bus_read(ADDR_CTRL, 8'h04, "ctrl_en_cleared");
        bus_read(ADDR_STATUS, 8'h01, "oneshot_tf");
        bus_read(ADDR_TCNT, 8'h00, "oneshot_tcnt");
        cycles(20);
        bus_read(ADDR_TCNT, 8'h00, "oneshot_tcnt_stays");

        // Reset mid-operation
        bus_write(ADDR_EMASK, 8'hFF);
        bus_write(4'h5, 8'h3C);
        bus_write(ADDR_TCNT, 8'h05);
        bus_write(ADDR_CTRL, 8'h07);
        port_in0 = 8'hFF;
        cycles(3);
        bus_read(ADDR_EDGE, 8'hFF, "edge_all");
        push(K_IRQ, "irq_before_reset", 64'h1);
        push(K_POUT, "pout_before_reset", 64'h0000_3C00_A500_0000);
        reset = 1'b1;
        port_in0 = 8'h00;
        cycles(1);
        reset = 1'b0;
        push(K_IRQ, "reset_irq", 64'h0);
        push(K_POUT, "reset_port_out", {8{OUT_RESET}});
        bus_read(ADDR_EDGE, 8'h00, "reset_edge");
        bus_read(ADDR_CTRL, 8'h00, "reset_ctrl");
        bus_read(ADDR_TCNT, 8'h00, "reset_tcnt");
        bus_read(ADDR_STATUS, 8'h00, "reset_status");
        bus_read(ADDR_EMASK, 8'h00, "reset_emask");
        bus_read(ADDR_TRELOAD, 8'h00, "reset_treload");

        cycles(2);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
